// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses PLL rst, qualifies lock with timeout and retries,
// then releases downstream domain resets in index order and re-sequences on lock loss.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned RELEASE_GAP_CYCLES  = 64,
    parameter int unsigned NUM_DOMAINS         = 3,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   soft_reset_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   all_ready,
    output logic                   lock_error,
    output logic [3:0]             retry_count,
    output logic [7:0]             relock_count
);

    localparam int unsigned PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned GW = $clog2(RELEASE_GAP_CYCLES + 1);

    localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK->STABLE edge already consumes the first qualified sample.
    localparam logic [SW-1:0] STABLE_LAST = SW'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
    localparam logic [GW-1:0] GAP_LAST    = GW'(RELEASE_GAP_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

    typedef enum logic [2:0] {
        S_ASSERT_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_sync_meta, r_locked_s;
    logic                   r_pll_rst, w_pll_rst_nxt;
    logic [NUM_DOMAINS-1:0] r_dom, w_dom_nxt, w_dom_shift;
    logic                   r_all_ready, w_all_ready_nxt;
    logic                   r_lock_err, w_lock_err_nxt;
    logic [3:0]             r_retry, w_retry_nxt, w_retry_inc;
    logic [7:0]             r_relock, w_relock_nxt;
    logic [PW-1:0]          r_pulse_cnt, w_pulse_nxt;
    logic [TW-1:0]          r_tmo_cnt, w_tmo_nxt;
    logic [SW-1:0]          r_stab_cnt, w_stab_nxt;
    logic [GW-1:0]          r_gap_cnt, w_gap_nxt;
    logic                   w_release_step, w_lock_loss;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
            r_state     <= S_ASSERT_RST;
            r_pll_rst   <= 1'b1;
            r_dom       <= '0;
            r_all_ready <= 1'b0;
            r_lock_err  <= 1'b0;
            r_retry     <= '0;
            r_relock    <= '0;
            r_pulse_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_stab_cnt  <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_sync_meta <= pll_locked;
            r_locked_s  <= r_sync_meta;
            r_state     <= w_state_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_dom       <= w_dom_nxt;
            r_all_ready <= w_all_ready_nxt;
            r_lock_err  <= w_lock_err_nxt;
            r_retry     <= w_retry_nxt;
            r_relock    <= w_relock_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_stab_cnt  <= w_stab_nxt;
            r_gap_cnt   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pll_rst_nxt   = r_pll_rst;
        w_dom_nxt       = r_dom;
        w_all_ready_nxt = r_all_ready;
        w_lock_err_nxt  = r_lock_err;
        w_retry_nxt     = r_retry;
        w_relock_nxt    = r_relock;
        w_pulse_nxt     = r_pulse_cnt;
        w_tmo_nxt       = r_tmo_cnt;
        w_stab_nxt      = r_stab_cnt;
        w_gap_nxt       = r_gap_cnt;
        w_release_step  = 1'b0;
        w_lock_loss     = 1'b0;
        w_retry_inc     = r_retry + 4'd1;
        // Domains release as a thermometer code, so shifting in a one frees the next index.
        w_dom_shift     = (r_dom << 1) | DOM_ONE;

        if (soft_reset_req) begin
            w_state_nxt     = S_ASSERT_RST;
            w_pll_rst_nxt   = 1'b1;
            w_dom_nxt       = '0;
            w_all_ready_nxt = 1'b0;
            w_lock_err_nxt  = 1'b0;
            w_retry_nxt     = '0;
            w_pulse_nxt     = '0;
            w_tmo_nxt       = '0;
            w_stab_nxt      = '0;
            w_gap_nxt       = '0;
        end else begin
            case (r_state)
                S_ASSERT_RST: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        w_state_nxt   = S_WAIT_LOCK;
                        w_pll_rst_nxt = 1'b0;
                        w_tmo_nxt     = '0;
                    end else begin
                        w_pulse_nxt = r_pulse_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_tmo_cnt == TMO_LAST) begin
                        w_retry_nxt   = w_retry_inc;
                        w_pll_rst_nxt = 1'b1;
                        w_tmo_nxt     = '0;
                        w_pulse_nxt   = '0;
                        if (w_retry_inc == 4'(MAX_RETRIES)) begin
                            w_state_nxt    = S_FAIL;
                            w_lock_err_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_ASSERT_RST;
                        end
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + 1'b1;
                        if (r_locked_s) begin
                            if (LOCK_STABLE_CYCLES == 1) begin
                                w_release_step = 1'b1;
                            end else begin
                                w_state_nxt = S_STABLE;
                                w_stab_nxt  = '0;
                            end
                        end
                    end
                end
                S_STABLE: begin
                    if (!r_locked_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else if (r_stab_cnt == STABLE_LAST) begin
                        w_release_step = 1'b1;
                    end else begin
                        w_stab_nxt = r_stab_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!r_locked_s) begin
                        w_lock_loss = 1'b1;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        w_release_step = 1'b1;
                    end else begin
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    w_retry_nxt = '0;
                    if (!r_locked_s) begin
                        w_lock_loss = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (w_lock_loss) begin
            w_state_nxt     = S_ASSERT_RST;
            w_pll_rst_nxt   = 1'b1;
            w_dom_nxt       = '0;
            w_all_ready_nxt = 1'b0;
            w_pulse_nxt     = '0;
            w_tmo_nxt       = '0;
            w_gap_nxt       = '0;
            if (r_relock != 8'hFF) begin
                w_relock_nxt = r_relock + 8'd1;
            end
        end

        if (w_release_step) begin
            w_dom_nxt = w_dom_shift;
            w_gap_nxt = '0;
            if (&w_dom_shift) begin
                w_state_nxt     = S_RUN;
                w_all_ready_nxt = 1'b1;
                w_retry_nxt     = '0;
            end else begin
                w_state_nxt = S_RELEASE;
            end
        end
    end

    assign pll_rst        = r_pll_rst;
    assign domain_reset_n = r_dom;
    assign all_ready      = r_all_ready;
    assign lock_error     = r_lock_err;
    assign retry_count    = r_retry;
    assign relock_count   = r_relock;

endmodule
